// File: rtl/rowwise_sum_buffer.sv
// Buffers one row of fixed-point elements, accumulates the saturated row sum, then replays (element, sum) beats.
// Optional build macro ROWWISE_SUM_ABS_EN accumulates |element| (L1 norm) instead of the signed element.
module rowwise_sum_buffer #(
   parameter int RowLength           = 16,
   parameter int FixedPointPrecision = 16
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           in_valid_i,
   output logic                           in_ready_o,
   input  logic [FixedPointPrecision-1:0] in_data_i,
   output logic                           out_valid_o,
   input  logic                           out_ready_i,
   output logic [FixedPointPrecision-1:0] out_a_o,
   output logic [FixedPointPrecision-1:0] out_b_o,
   output logic                           out_last_o,
   output logic                           busy_o
);

   localparam int P         = FixedPointPrecision;
   localparam int CntWidth  = $clog2(RowLength) + 1;
   localparam int AccWidth  = P + $clog2(RowLength) + 1;
   localparam int AddrWidth = $clog2(RowLength);

   typedef logic signed [P-1:0] fixed_point_t;
   localparam fixed_point_t FixedPointMax = {1'b0, {(P-1){1'b1}}};
   localparam fixed_point_t FixedPointMin = {1'b1, {(P-1){1'b0}}};
   localparam logic signed [AccWidth-1:0] AccMax = {{(AccWidth-P+1){1'b0}}, {(P-1){1'b1}}};
   localparam logic signed [AccWidth-1:0] AccMin = {{(AccWidth-P+1){1'b1}}, {(P-1){1'b0}}};

   typedef enum logic {FILL, DRAIN} state_t;

   state_t                      state;
   logic [CntWidth-1:0]         wr_cnt;
   logic [CntWidth-1:0]         rd_cnt;
   logic signed [AccWidth-1:0]  acc;
   logic signed [AccWidth-1:0]  acc_sum;
   fixed_point_t                addend;
   fixed_point_t                sat_sum;
   fixed_point_t                sum_q;
   fixed_point_t                out_a;
   logic                        out_last;
   fixed_point_t                row_buf [RowLength];
   logic                        in_fire;
   logic                        out_fire;
   logic                        last_in;
   logic [AddrWidth-1:0]        wr_addr;
   logic [AddrWidth-1:0]        rd_next_addr;
   logic [CntWidth-1:0]         rd_cnt_inc;

   assign in_fire      = (state == FILL) && in_valid_i;
   assign out_fire     = (state == DRAIN) && out_ready_i;
   assign last_in      = (wr_cnt == CntWidth'(RowLength - 1));
   assign wr_addr      = AddrWidth'(wr_cnt);
   assign rd_cnt_inc   = rd_cnt + 1'b1;
   assign rd_next_addr = AddrWidth'(rd_cnt_inc);

   always_comb begin
`ifdef ROWWISE_SUM_ABS_EN
      // The most negative value has no positive twin, so clamp it before accumulating.
      if (in_data_i == FixedPointMin)
         addend = FixedPointMax;
      else if (in_data_i[P-1])
         addend = -in_data_i;
      else
         addend = in_data_i;
`else
      addend = in_data_i;
`endif
      acc_sum = acc + $signed({{(AccWidth-P){addend[P-1]}}, addend});
      if (acc_sum > AccMax)
         sat_sum = FixedPointMax;
      else if (acc_sum < AccMin)
         sat_sum = FixedPointMin;
      else
         sat_sum = acc_sum[P-1:0];
   end

   always_ff @(posedge clk_i) begin
      if (in_fire)
         row_buf[wr_addr] <= in_data_i;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state    <= FILL;
         wr_cnt   <= '0;
         rd_cnt   <= '0;
         acc      <= '0;
         sum_q    <= '0;
         out_a    <= '0;
         out_last <= 1'b0;
      end else begin
         case (state)
            FILL: begin
               if (in_fire) begin
                  acc    <= acc_sum;
                  wr_cnt <= wr_cnt + 1'b1;
                  if (last_in) begin
                     // Index 0 was written several cycles ago, so it is safe to read on this edge.
                     state    <= DRAIN;
                     sum_q    <= sat_sum;
                     out_a    <= row_buf[0];
                     out_last <= 1'b0;
                  end
               end
            end
            DRAIN: begin
               if (out_fire) begin
                  if (out_last) begin
                     state    <= FILL;
                     rd_cnt   <= '0;
                     wr_cnt   <= '0;
                     acc      <= '0;
                     out_last <= 1'b0;
                  end else begin
                     rd_cnt   <= rd_cnt_inc;
                     out_a    <= row_buf[rd_next_addr];
                     out_last <= (rd_cnt_inc == CntWidth'(RowLength - 1));
                  end
               end
            end
            default: state <= FILL;
         endcase
      end
   end

   assign in_ready_o  = (state == FILL);
   assign out_valid_o = (state == DRAIN);
   assign busy_o      = (state == DRAIN) || (wr_cnt != '0);
   assign out_a_o     = out_a;
   assign out_b_o     = sum_q;
   assign out_last_o  = out_last;

endmodule

// File: tb/tb_rowwise_sum_buffer.sv
// Randomised and directed bench for rowwise_sum_buffer (RowLength=4) against a row-level arithmetic model.
module tb_rowwise_sum_buffer;

   localparam int  RL  = 4;
   localparam int  P   = 16;
   localparam longint MAXV = 32767;
   localparam longint MINV = -32768;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [P-1:0]      in_data = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic signed [P-1:0] out_a;
   logic signed [P-1:0] out_b;
   logic              out_last;
   logic              busy;

   int n_checks = 0;
   int n_fail   = 0;

   rowwise_sum_buffer #(.RowLength(RL), .FixedPointPrecision(P)) dut (
      .clk_i(clk), .rst_i(rst),
      .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
      .out_valid_o(out_valid), .out_ready_i(out_ready),
      .out_a_o(out_a), .out_b_o(out_b), .out_last_o(out_last), .busy_o(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input longint obs, input longint exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic longint model_sum(input int v[RL]);
      longint s = 0;
      longint e;
      foreach (v[i]) begin
         e = v[i];
`ifdef ROWWISE_SUM_ABS_EN
         if (e < 0) e = -e;
         if (e > MAXV) e = MAXV;
`endif
         s += e;
      end
      if (s > MAXV) s = MAXV;
      else if (s < MINV) s = MINV;
      return s;
   endfunction

   task automatic check_reset_outputs(input string tag);
      check({tag, "_in_ready"}, in_ready, 1);
      check({tag, "_out_valid"}, out_valid, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_out_last"}, out_last, 0);
      check({tag, "_out_a"}, out_a, 0);
      check({tag, "_out_b"}, out_b, 0);
   endtask

   task automatic load_row(input int v[RL], input bit gaps);
      for (int i = 0; i < RL; i++) begin
         if (gaps) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin
               @(posedge clk); #1;
            end
         end
         if (i == 0) check("busy_idle", busy, 0);
         check("in_ready_fill", in_ready, 1);
         check("out_valid_fill", out_valid, 0);
         in_valid = 1'b1;
         in_data  = P'(v[i]);
         @(posedge clk); #1;
         check("busy_fill", busy, 1);
      end
      in_valid = 1'b0;
   endtask

   // mode 0: always ready, 1: fixed stall pattern, 2: random stalls
   task automatic drain_row(input int v[RL], input int mode, input bit hold_in);
      longint s = model_sum(v);
      int beat = 0;
      int cyc  = 0;
      int pat[7] = '{1, 0, 0, 1, 0, 1, 1};
      if (hold_in) begin
         in_valid = 1'b1;
         in_data  = 16'h0063;
      end
      while (beat < RL && cyc < 64) begin
         check("out_valid", out_valid, 1);
         check("in_ready_drain", in_ready, 0);
         check("busy_drain", busy, 1);
         check("out_a", out_a, v[beat]);
         check("out_b", out_b, s);
         check("out_last", out_last, (beat == RL - 1) ? 1 : 0);
         if (mode == 0)      out_ready = 1'b1;
         else if (mode == 1) out_ready = (cyc < 7) ? pat[cyc][0] : 1'b1;
         else                out_ready = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         if (out_ready) beat++;
         cyc++;
      end
      if (beat < RL) check("drain_timeout", beat, RL);
      if (mode == 0) check("drain_cycles", cyc, RL);
      out_ready = 1'b0;
      in_valid  = 1'b0;
      check("out_valid_after", out_valid, 0);
      check("in_ready_after", in_ready, 1);
      check("busy_after", busy, 0);
   endtask

   task automatic row(input int v[RL], input int mode, input bit gaps, input bit hold_in);
      $display("row %0d,%0d,%0d,%0d mode=%0d expected sum=%0d", v[0], v[1], v[2], v[3], mode, model_sum(v));
      load_row(v, gaps);
      drain_row(v, mode, hold_in);
   endtask

   task automatic mid_reset(input string tag);
      #3 rst = 1'b1;
      #1 check_reset_outputs(tag);
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      int v[RL];
      repeat (2) @(posedge clk);
      #1 check_reset_outputs("reset");
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;

      row('{1, 2, 3, 4}, 0, 1'b0, 1'b0);
      row('{-1, -2, -3, -4}, 0, 1'b0, 1'b0);
      row('{32767, 32767, 32767, 32767}, 0, 1'b0, 1'b0);
      row('{-32768, -32768, -32768, -32768}, 0, 1'b0, 1'b0);
      row('{11, -22, 33, -44}, 1, 1'b0, 1'b1);
      row('{5, -5, 3, -3}, 0, 1'b0, 1'b0);
      row('{1, 1, 1, 1}, 0, 1'b0, 1'b0);

      // reset after two accepted inputs
      in_valid = 1'b1;
      for (int i = 0; i < 2; i++) begin
         in_data = P'(100 + i);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      mid_reset("reset_fill");
      row('{2, 4, 6, 8}, 0, 1'b0, 1'b0);

      // reset after two drained beats
      load_row('{7, 8, 9, 10}, 1'b0);
      out_ready = 1'b1;
      repeat (2) begin
         @(posedge clk); #1;
      end
      out_ready = 1'b0;
      check("partial_drain_out_a", out_a, 9);
      mid_reset("reset_drain");
      row('{-7, 3, 12, -1}, 0, 1'b0, 1'b0);

      for (int r = 0; r < 20; r++) begin
         for (int i = 0; i < RL; i++) begin
            case ($urandom_range(0, 3))
               0:       v[i] = int'($urandom_range(0, 65535)) - 32768;
               1:       v[i] = ($urandom_range(0, 1) == 1) ? 32767 : -32768;
               default: v[i] = int'($urandom_range(0, 200)) - 100;
            endcase
         end
         row(v, 2, 1'b1, ($urandom_range(0, 1) == 1));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
